inv_sub_bytes_serial: RTL
=========================

# inv_sub_bytes_serial

Sequential inverse byte-substitution engine for the AES-256 decryption datapath. It accepts one 128-bit state word through a valid/ready handshake and applies the FIPS-197 inverse S-box to all 16 bytes, LANES bytes per clock. It returns the result through a second valid/ready handshake. It sits between the inverse-ShiftRows and AddRoundKey stages of the decrypt round, and lets area-constrained builds trade latency for fewer inverse S-box instances.

## Interface
- LANES, default 4: bytes substituted per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state word.
- in_data  input  128  state word; byte 0 = [127:120], byte 15 = [7:0].
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  inverse-substituted state, same byte ordering as in_data.
- busy  output  1  high in RUN or DONE.
- err  output  1  self-check failure flag; see Configuration.

## Operation
- Contains LANES combinational inv_s_box instances (8-bit FIPS-197 inverse table).
- Holds a 128-bit working register, a group counter cnt of width clog2(16/LANES) (minimum 1 bit), and a 3-state FSM.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load the working register with in_data, cnt=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, replace bytes cnt*LANES .. cnt*LANES+LANES-1 with their inverse S-box values, processing from the MSB byte downward, then increment cnt.
  - When the last group (cnt=16/LANES-1) is written, go to DONE.
- DONE:
  - out_valid=1; out_data is the working register, held stable.
  - On out_ready=1, go to IDLE.
  - out_ready low holds DONE indefinitely with no data change.
- in_ready is high only in IDLE. There is no input/output overlap: a block cannot be accepted in the same cycle a result is consumed.
- in_data and in_valid are ignored outside IDLE.
- Bytes not yet processed stay untouched. out_data is only meaningful while out_valid=1.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, err=0, out_data=128'h0, cnt=0, state=IDLE.
- Latency: with K=16/LANES, out_valid rises K clock edges after the accepting edge. K=1 for LANES=16 and K=16 for LANES=1.
- Throughput: one block per K+2 cycles when out_ready is held high.
- in_ready drops on the edge following acceptance.
- out_valid drops on the edge where out_valid&&out_ready. in_ready is high in the next cycle.
- Reset asserted in RUN or DONE: the FSM goes to IDLE immediately (asynchronously), out_valid=0, and the partial result is discarded. No output handshake occurs for the aborted block.
- cnt never wraps inside RUN; it is reset to 0 on every accept.

## Configuration
- Macro: INV_SUB_BYTES_SELFCHECK_EN.
- Defined:
  - Adds LANES forward s_box instances. Each processed byte is re-substituted forward and compared to its original value.
  - Any mismatch sets err, which is sticky until the next accept or reset.
  - err is registered and valid by the time out_valid rises.
- Undefined: no forward s_box instances are built, and err is tied to 0.

## Test plan
- Reset then idle: in_ready=1, out_valid=0, out_data=0, busy=0.
- in_data=128'h6363...63 (all bytes 0x63), out_ready=1 -> exactly K cycles later out_valid=1 and out_data=all 0x00; in_ready=1 one cycle after the output handshake.
- in_data=128'h00000000_00000000_00000000_000016FF -> out_data=128'h52525252_52525252_52525252_5252FF7D (InvS(0x16)=0xFF, InvS(0xFF)=0x7D).
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready=0, and in_valid pulses are ignored.
- Assert rst mid-RUN (after 2 groups, LANES=4) -> out_valid=0 and in_ready=1 immediately; a new block of all 0x7C then yields all 0x01.
- Sweep LANES over 1, 2, 4, 8 and 16 with the same vector -> identical out_data and latency of 16, 8, 4, 2 and 1 cycles; with INV_SUB_BYTES_SELFCHECK_EN defined, err stays 0 throughout.

Source files
------------

// File: rtl/inv_sub_bytes_serial_if.sv
// Handshake bundle for inv_sub_bytes_serial.
// Valid/ready rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high. Once valid is raised, the sender
// keeps valid and data stable until that edge. Ready may change freely.
interface inv_sub_bytes_serial_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inv_sub_bytes_serial.sv
// inv_sub_bytes_serial: applies the AES inverse S-box to a 128-bit state word,
// LANES bytes per clock, starting at byte 0 ([127:120]).
// Optional forward re-substitution self-check: define INV_SUB_BYTES_SELFCHECK_EN.

module inv_s_box (
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);
    localparam logic [2047:0] INV_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Entry 0 sits in the top byte of the table constant.
    assign o_y = INV_TAB[8*(255 - int'(i_x)) +: 8];
endmodule

`ifdef INV_SUB_BYTES_SELFCHECK_EN
module s_box (
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);
    localparam logic [2047:0] FWD_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte of the table constant.
    assign o_y = FWD_TAB[8*(255 - int'(i_x)) +: 8];
endmodule
`endif

module inv_sub_bytes_serial #(
    parameter int LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    inv_sub_bytes_serial_if.slave        bus,
    output logic                         busy,
    output logic                         err,
    output logic [1:0]                   o_dbg_state
);
    localparam int K     = 16 / LANES;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [127:0]       r_work;
    logic [127:0]       w_work_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_accept;
    logic               w_last;
    logic [7:0]         w_cur [LANES];
    logic [7:0]         w_sub [LANES];

    assign w_accept    = (r_state == S_IDLE) && bus.in_valid;
    assign w_last      = (r_cnt == CNT_W'(K - 1));
    assign o_dbg_state = r_state;

    // One inverse S-box per lane; lane j handles byte cnt*LANES+j.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_s_box u_inv (
            .i_x (w_cur[g]),
            .o_y (w_sub[g])
        );
    end

    // FSM state register; reset aborts any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs, all decoded from the current state.
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (bus.in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.out_data = r_work;

    // Pick out the current group's bytes, MSB byte first.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            w_cur[j] = r_work[8*(15 - (int'(r_cnt) * LANES + j)) +: 8];
        end
    end

    // Working word with the current group replaced by its substituted bytes.
    always_comb begin
        w_work_nxt = r_work;
        for (int j = 0; j < LANES; j++) begin
            w_work_nxt[8*(15 - (int'(r_cnt) * LANES + j)) +: 8] = w_sub[j];
        end
    end

    // Working register and group counter; cnt stops on the last group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work <= 128'h0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_work <= bus.in_data;
            r_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            r_work <= w_work_nxt;
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef INV_SUB_BYTES_SELFCHECK_EN
    logic [7:0] w_chk [LANES];
    logic       w_mis;
    logic       r_err;

    // Forward S-box on each result byte must give back the original byte.
    for (genvar g = 0; g < LANES; g++) begin : g_chk
        s_box u_fwd (
            .i_x (w_sub[g]),
            .o_y (w_chk[g])
        );
    end

    // Any lane whose round trip does not match flags a mismatch this cycle.
    always_comb begin
        w_mis = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            if (w_chk[j] != w_cur[j]) begin
                w_mis = 1'b1;
            end
        end
    end

    // Sticky error flag, cleared when a new block is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if ((r_state == S_RUN) && w_mis) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif
endmodule
